// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX sequencer and the sampler/checker slices.
// The master side is the sequencer; the slave side is whatever drives the line and
// the checker results (the checker slices, or a testbench).
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;

  logic          RX_IN;
  logic          PAR_EN;
  logic [5:0]    Prescale;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [4:0]    edge_count;
  logic [BW-1:0] bit_count;
  logic          dat_samp_en;
  logic          deser_en;
  logic          start_check_en;
  logic          parity_check_en;
  logic          stop_check_en;
  logic          data_valid;

  modport master (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_count, bit_count, dat_samp_en, deser_en,
           start_check_en, parity_check_en, stop_check_en, data_valid
  );

  modport slave (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_count, bit_count, dat_samp_en, deser_en,
           start_check_en, parity_check_en, stop_check_en, data_valid
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX sequencer: owns the oversampling edge counter and the data bit counter,
// walks each frame through START/DATA/PARITY/STOP and enables the sampler,
// deserializer and checkers in turn. data_valid pulses only for clean frames.
// Every output is a register; enables are computed from the next state so that
// they line up with the state/edge_count the downstream slices observe.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.master bus
);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_reg, state_next;
  logic [4:0]    edge_reg, edge_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic          par_en_q_reg, par_en_q_next;
  logic          data_valid_reg, data_valid_next;
  logic          dat_samp_en_reg, deser_en_reg;
  logic          start_chk_reg, par_chk_reg, stop_chk_reg;

  logic [5:0]    presc_eff;
  logic [4:0]    last_edge;
  logic [5:0]    deser_edge;
  logic          at_le;

  // Bit timing derived from Prescale: floor at 8, last edge capped at 31, and the
  // deserializer strobe one edge after the checker sample point (Prescale/2+2).
  always_comb begin
    presc_eff  = (bus.Prescale < 6'd8) ? 6'd8 : bus.Prescale;
    last_edge  = (presc_eff > 6'd32) ? 5'd31 : 5'(presc_eff - 6'd1);
    deser_edge = {1'b0, presc_eff[5:1]} + 6'd3;
    // ">=" keeps the counter bounded if Prescale shrinks mid-frame.
    at_le      = (edge_reg >= last_edge);
  end

  // Next-state, counters and data_valid decision.
  always_comb begin
    state_next      = state_reg;
    bit_next        = bit_reg;
    par_en_q_next   = par_en_q_reg;
    data_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_next    = START;
          par_en_q_next = bus.PAR_EN;
        end
      end
      START: begin
        if (at_le) begin
          if (bus.strt_glitch) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            bit_next   = '0;
          end
        end
      end
      DATA: begin
        if (at_le) begin
          if (bit_reg == LAST_BIT) begin
            state_next = par_en_q_reg ? PARITY : STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_le) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (at_le) begin
          state_next = IDLE;
          // A stale par_err from an earlier parity frame must not veto this one.
          data_valid_next = !bus.stp_err && (!par_en_q_reg || !bus.par_err);
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE) begin
      bit_next = '0;
    end
    edge_next = (state_reg == IDLE || at_le) ? 5'd0 : edge_reg + 5'd1;
  end

  // State, counters and registered enables; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      edge_reg        <= 5'd0;
      bit_reg         <= '0;
      par_en_q_reg    <= 1'b0;
      data_valid_reg  <= 1'b0;
      dat_samp_en_reg <= 1'b0;
      deser_en_reg    <= 1'b0;
      start_chk_reg   <= 1'b0;
      par_chk_reg     <= 1'b0;
      stop_chk_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      edge_reg        <= edge_next;
      bit_reg         <= bit_next;
      par_en_q_reg    <= par_en_q_next;
      data_valid_reg  <= data_valid_next;
      dat_samp_en_reg <= (state_next != IDLE);
      deser_en_reg    <= (state_next == DATA) && ({1'b0, edge_next} == deser_edge);
      start_chk_reg   <= (state_next == START);
      par_chk_reg     <= (state_next == PARITY);
      stop_chk_reg    <= (state_next == STOP);
    end
  end

  assign bus.edge_count      = edge_reg;
  assign bus.bit_count       = bit_reg;
  assign bus.dat_samp_en     = dat_samp_en_reg;
  assign bus.deser_en        = deser_en_reg;
  assign bus.start_check_en  = start_chk_reg;
  assign bus.parity_check_en = par_chk_reg;
  assign bus.stop_check_en   = stop_chk_reg;
  assign bus.data_valid      = data_valid_reg;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. A frame-level model predicts every output from the offset
// of the current cycle within the frame (bit = offset / P, edge = offset % P).
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();
  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;

  // Frame model state
  bit m_active = 1'b0;
  int m_k = 0;
  int m_p = 8;
  bit m_par = 1'b0;
  int m_len = 0;
  bit m_good = 1'b0;
  bit m_dv = 1'b0;
  int cyc = 0;
  int m_start_cyc = 0;

  // Monitor counters (cumulative)
  int deser_cnt = 0, dv_cnt = 0, pchk_cnt = 0, strt_cnt = 0, dv_cyc = 0;

  function automatic int eff_p(input logic [5:0] pr);
    return (pr < 6'd8) ? 8 : int'(pr);
  endfunction

  // Frame model: a frame starts when the line is seen low while idle, lasts
  // (10 + parity) bit periods (one period if the start bit is a glitch), and
  // data_valid shows up in the single idle cycle that follows.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_dv     <= 1'b0;
    end else begin
      cyc  <= cyc + 1;
      m_dv <= 1'b0;
      if (m_active) begin
        if (m_k == m_len - 1) begin
          m_active <= 1'b0;
          m_dv     <= m_good;
        end else begin
          m_k <= m_k + 1;
        end
      end else if (bus.RX_IN == 1'b0) begin
        m_active    <= 1'b1;
        m_k         <= 0;
        m_p         <= eff_p(bus.Prescale);
        m_par       <= bus.PAR_EN;
        m_len       <= bus.strt_glitch ? eff_p(bus.Prescale)
                                       : (10 + int'(bus.PAR_EN)) * eff_p(bus.Prescale);
        m_good      <= !bus.strt_glitch && !bus.stp_err && !(bus.PAR_EN && bus.par_err);
        m_start_cyc <= cyc + 1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Serial line level at a given offset within the frame.
  function automatic logic line_at(input int i, input int p, input bit pe,
                                   input logic [7:0] d, input bit glitch,
                                   input bit perr, input bit serr);
    int b;
    b = i / p;
    if (glitch) return (i < 2) ? 1'b0 : 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return (^d) ^ perr;
    if (b == 9 + int'(pe)) return !serr;
    return 1'b1;
  endfunction

  // Drives one frame. abort_bit >= 0 asserts rst mid-DATA at that bit index.
  task automatic send_frame(input logic [5:0] pres, input bit pe, input logic [7:0] d,
                            input bit glitch, input bit perr, input bit serr,
                            input int gap, input int abort_bit, input bit flip_pe);
    int p, len;
    p   = eff_p(pres);
    len = glitch ? p : (10 + int'(pe)) * p;
    repeat (gap) begin
      @(negedge clk);
      bus.RX_IN = 1'b1;
    end
    @(negedge clk);
    bus.Prescale    = pres;
    bus.PAR_EN      = pe;
    bus.strt_glitch = glitch;
    bus.par_err     = perr;
    bus.stp_err     = serr;
    bus.RX_IN       = 1'b0;
    frame_no++;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      bus.RX_IN = line_at(i, p, pe, d, glitch, perr, serr);
      if (flip_pe && i == len / 2) bus.PAR_EN = ~bus.PAR_EN;
      if (abort_bit >= 0 && i == (1 + abort_bit) * p + 3) begin
        chk("bit_count_before_abort", int'(bus.bit_count), abort_bit);
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs_zero",
            int'({bus.edge_count, bus.bit_count, bus.dat_samp_en, bus.deser_en,
                  bus.start_check_en, bus.parity_check_en, bus.stop_check_en,
                  bus.data_valid}), 0);
        @(negedge clk);
        bus.RX_IN = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] frame %0d P=%0d par=%0d data=%h aborted by reset at bit %0d",
                 frame_no, p, pe, d, abort_bit);
        return;
      end
    end
    $display("[TB] frame %0d P=%0d par=%0d data=%h glitch=%0d perr=%0d serr=%0d",
             frame_no, p, pe, d, glitch, perr, serr);
  endtask

  int d0, v0, p0, s0;

  initial begin
    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
    bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
    fork
      begin : compare
        int b, e, sp1;
        logic [14:0] got, want;
        logic [4:0] x_edge;
        logic [3:0] x_bit;
        logic x_samp, x_deser, x_strt, x_par, x_stop, x_dv;
        @(posedge clk);
        forever begin
          @(negedge clk);
          x_edge = '0; x_bit = '0; x_samp = 1'b0; x_deser = 1'b0;
          x_strt = 1'b0; x_par = 1'b0; x_stop = 1'b0; x_dv = 1'b0;
          if (m_active) begin
            b = m_k / m_p;
            e = m_k % m_p;
            sp1 = m_p / 2 + 3;
            x_edge  = 5'(e);
            x_samp  = 1'b1;
            x_strt  = (b == 0);
            x_deser = (b >= 1 && b <= 8 && e == sp1);
            x_bit   = (b >= 1 && b <= 8) ? 4'(b - 1) : ((b == 0) ? 4'd0 : 4'd7);
            x_par   = m_par && (b == 9);
            x_stop  = (b == 9 + int'(m_par));
          end else begin
            x_dv = m_dv;
          end
          got  = {bus.edge_count, bus.bit_count, bus.dat_samp_en, bus.deser_en,
                  bus.start_check_en, bus.parity_check_en, bus.stop_check_en,
                  bus.data_valid};
          want = {x_edge, x_bit, x_samp, x_deser, x_strt, x_par, x_stop, x_dv};
          n_tests++;
          if (got !== want) begin
            n_fail++;
            $display("FAIL cycle_outputs cyc=%0d {edge,bit,samp,deser,strt,par,stop,dv} got %h want %h",
                     cyc, got, want);
          end
          if (bus.deser_en) deser_cnt++;
          if (bus.parity_check_en) pchk_cnt++;
          if (bus.start_check_en) strt_cnt++;
          if (bus.data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
          end
        end
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_edge_count", int'(bus.edge_count), 0);
    chk("reset_bit_count", int'(bus.bit_count), 0);
    chk("reset_dat_samp_en", int'(bus.dat_samp_en), 0);
    chk("reset_data_valid", int'(bus.data_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // P=8, no parity, 0xA5, good stop
    d0 = deser_cnt; v0 = dv_cnt;
    send_frame(6'd8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t1_deser_pulses", deser_cnt - d0, 8);
    chk("t1_data_valid_count", dv_cnt - v0, 1);
    chk("t1_data_valid_latency", dv_cyc - m_start_cyc, 80);

    // P=16, even parity, 0x3C, correct parity
    p0 = pchk_cnt; v0 = dv_cnt;
    send_frame(6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t2_parity_check_cycles", pchk_cnt - p0, 16);
    chk("t2_data_valid_count", dv_cnt - v0, 1);

    // Same, parity bit flipped
    v0 = dv_cnt;
    send_frame(6'd16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t3_data_valid_count", dv_cnt - v0, 0);
    chk("t3_idle_after_stop", int'(bus.dat_samp_en), 0);

    // Start glitch
    d0 = deser_cnt; v0 = dv_cnt; s0 = strt_cnt;
    send_frame(6'd8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t4_deser_pulses", deser_cnt - d0, 0);
    chk("t4_data_valid_count", dv_cnt - v0, 0);
    chk("t4_start_check_cycles", strt_cnt - s0, 8);

    // Stop error with stale par_err; then good stop, par_err ignored
    v0 = dv_cnt;
    send_frame(6'd8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t5_stop_err_no_valid", dv_cnt - v0, 0);
    v0 = dv_cnt;
    send_frame(6'd8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t5_stale_par_err_ignored", dv_cnt - v0, 1);

    // Reset mid-DATA at bit 4, then a clean frame
    v0 = dv_cnt;
    send_frame(6'd16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1, 4, 1'b0);
    send_frame(6'd16, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
    @(negedge clk); #1;
    chk("t6_valid_after_abort", dv_cnt - v0, 1);

    // Randomized frames, including back-to-back, Prescale floor and PAR_EN flips
    for (int n = 0; n < 40; n++) begin
      logic [5:0] pr;
      case ($urandom_range(0, 4))
        0: pr = 6'd8;
        1: pr = 6'd16;
        2: pr = 6'd32;
        3: pr = 6'($urandom_range(0, 7));
        default: pr = 6'd16;
      endcase
      send_frame(pr, 1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1,
                 ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
